axis_pkt_sched: RTL and testbench
=================================

# axis_pkt_sched

Packet-granular round-robin scheduler that shares one AXI-Stream master (toward the DMA S2MM channel) between `N_SRC` first-word-fall-through receive FIFOs. A source is granted only when its FIFO holds a complete packet of `PKT_LEN` words. The scheduler then streams exactly that packet with `m_axis_tlast` on the final beat and tags it with the source index on `m_axis_tdest`. It replaces the free-running per-FIFO packetizer where several LVDS-SPI channels feed one DMA.

## Interface
Parameters:
- `N_SRC`, 4, number of source FIFOs (2..8)
- `DATA_WIDTH`, 32, stream/FIFO word width
- `PKT_LEN`, 512, beats per packet (≥2)
- `LVL_WIDTH`, 10, FIFO fill-level width; must satisfy 2^LVL_WIDTH > PKT_LEN
- `ID_WIDTH`, 2, width of `m_axis_tdest`; 2^ID_WIDTH ≥ N_SRC
- `CNT_WIDTH`, 16, packet counter / limit width

Ports:
- `clk` in 1 — single clock
- `rst_L` in 1 — reset, asynchronous assert, active-low
- `i_enable` in 1 — run request
- `i_pkt_limit` in CNT_WIDTH — packets to send per run; 0 = unlimited
- `i_fifo_data` in N_SRC*DATA_WIDTH — FWFT head word, source k at slice k
- `i_fifo_level` in N_SRC*LVL_WIDTH — fill level, source k at slice k
- `o_fifo_en` out N_SRC — one-hot pop strobe
- `m_axis_tvalid` out 1, `m_axis_tready` in 1
- `m_axis_tdata` out DATA_WIDTH, `m_axis_tkeep` out DATA_WIDTH/8 (constant all-ones)
- `m_axis_tlast` out 1, `m_axis_tdest` out ID_WIDTH
- `o_busy` out 1 — state ≠ IDLE
- `o_done` out 1 — limit reached
- `o_pkt_cnt` out CNT_WIDTH — packets completed this run

## Operation
- States: IDLE, ARB, XFER, DONE.
- IDLE: on `i_enable`=1, clear `o_pkt_cnt` and go to ARB.
- ARB: eligible(k) = level_k ≥ PKT_LEN.
  - Rotate priority starting at (last_grant+1) mod N_SRC. Winner → register `grant`, clear beat counter, go to XFER.
  - No eligible source: stay in ARB.
  - `i_enable`=0 → IDLE.
- XFER:
  - `m_axis_tvalid`=1; `m_axis_tdata` = head of `grant` FIFO; `m_axis_tdest` = `grant`.
  - `o_fifo_en[grant]` = tvalid & tready (combinational).
  - Beat counter increments per handshake; `m_axis_tlast` = (beat == PKT_LEN-1).
- On the last handshake:
  - `o_pkt_cnt`++ and last_grant ← grant.
  - If `i_pkt_limit`≠0 and the new count == `i_pkt_limit` → DONE.
  - Else if `i_enable`=0 → IDLE.
  - Else → ARB.
- `i_enable` falling mid-packet never truncates: the packet completes, then the block goes to IDLE.
- DONE: `o_done`=1 and `m_axis_tvalid`=0; leave to IDLE when `i_enable`=0.
- `o_pkt_cnt` saturates at all-ones; it holds its value in IDLE until the next run starts.
- `i_pkt_limit` is sampled on the IDLE→ARB transition.

## Timing
- Reset values: `m_axis_tvalid`, `m_axis_tlast`, `o_fifo_en`, `o_busy`, `o_done` = 0; `m_axis_tdest` = 0; `o_pkt_cnt` = 0; last_grant = N_SRC-1 (first scan starts at source 0); state IDLE.
- Latency:
  - IDLE→ARB: 1 cycle.
  - ARB decision: 1 cycle.
  - First tvalid appears in the cycle after ARB.
  - Minimum bubble between packets: 1 cycle (the ARB cycle).
- AXIS rules:
  - Once tvalid is asserted, tvalid, tdata, tlast and tdest stay stable until the handshake. FWFT head does not change without a pop.
  - tready low for any duration is legal.
- Underflow cannot occur: the level is checked for ≥ PKT_LEN at grant, and only this block pops that FIFO. Level increases during a packet are ignored.
- Simultaneous eligibility: strict rotation. With all sources full, the grant order is 0,1,…,N_SRC-1,0.
- Reset asserted mid-packet: all outputs go to reset values immediately; the partial packet is abandoned. Recovery of the DMA is software's job.

## Structure
- Package `axis_pkt_sched_pkg`: state enum `sched_state_t` (IDLE, ARB, XFER, DONE) and the state encoding width.
- Sub-module `rr_arbiter` (parameter N), combinational:
  - Inputs: request vector, last-grant index.
  - Outputs: one-hot grant, index, any-valid.
  - Instantiated once in ARB.
- Top holds the FSM, beat counter (clog2(PKT_LEN) bits), packet counter and output muxes.

## Test plan
- Single source: N_SRC=4, PKT_LEN=8, source 2 level=8, tready=1 → 8 beats with tdest=2, tlast on beat 8 only, 8 pops, `o_pkt_cnt`=1.
- Fairness: all 4 levels ≥16, limit=8 → tdest sequence 0,1,2,3,0,1,2,3 with one idle cycle between packets, then `o_done`=1 and tvalid=0.
- Backpressure: toggle tready randomly during a packet → tdata/tlast stable while tready=0, pops only on handshake, 8 unique words delivered in order.
- Threshold: source 1 level=7 → no grant; level becomes 8 → grant within 2 cycles.
- Disable mid-packet: drop `i_enable` at beat 3 → packet completes all 8 beats, then IDLE, `o_busy`=0.
- Reset mid-packet: assert `rst_L`=0 at beat 5 → tvalid, `o_fifo_en`, `o_pkt_cnt` are 0 in the same cycle; after release with enable=1, the next grant starts at source 0.

Source files
------------

// File: rtl/axis_pkt_sched_pkg.sv
// Shared types for the packet scheduler: FSM state encoding.
package axis_pkt_sched_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: scan starts one past the last grant.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // NOTE: combinational blocks use blocking assignments and give every output
  // a default first, so no latch can be inferred on any path.
  always_comb begin
    int k;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    k       = 0;
    for (int i = 1; i <= N; i++) begin
      k = int'(last_i) + i;
      if (k >= N) k = k - N;
      if (!valid_o && req_i[k]) begin
        valid_o  = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/axis_pkt_sched.sv
// Packet-granular round-robin scheduler: N_SRC FWFT FIFOs onto one AXI-Stream
// master, granting a source only when it holds a full PKT_LEN-word packet.
module axis_pkt_sched
  import axis_pkt_sched_pkg::*;
#(
  parameter int N_SRC      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int PKT_LEN    = 512,
  parameter int LVL_WIDTH  = 10,
  parameter int ID_WIDTH   = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_L,
  input  logic                          i_enable,
  input  logic [CNT_WIDTH-1:0]          i_pkt_limit,
  input  logic [N_SRC*DATA_WIDTH-1:0]   i_fifo_data,
  input  logic [N_SRC*LVL_WIDTH-1:0]    i_fifo_level,
  output logic [N_SRC-1:0]              o_fifo_en,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]       m_axis_tkeep,
  output logic                          m_axis_tlast,
  output logic [ID_WIDTH-1:0]           m_axis_tdest,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [CNT_WIDTH-1:0]          o_pkt_cnt
);

  localparam int                    BEAT_W    = $clog2(PKT_LEN);
  localparam logic [BEAT_W-1:0]     BEAT_LAST = BEAT_W'(PKT_LEN - 1);
  localparam logic [LVL_WIDTH-1:0]  LVL_PKT   = LVL_WIDTH'(PKT_LEN);

  sched_state_t          state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]   last_q, last_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  limit_q, limit_d;

  logic [N_SRC-1:0]      eligible;
  logic [N_SRC-1:0]      arb_gnt;
  logic [ID_WIDTH-1:0]   arb_idx;
  logic                  arb_valid;
  logic                  xfer;
  logic                  handshake;
  logic [CNT_WIDTH-1:0]  cnt_inc;

  always_comb begin
    eligible = '0;
    for (int k = 0; k < N_SRC; k++)
      eligible[k] = i_fifo_level[k*LVL_WIDTH +: LVL_WIDTH] >= LVL_PKT;
  end

  rr_arbiter #(
    .N     (N_SRC),
    .IDX_W (ID_WIDTH)
  ) u_arb (
    .req_i   (eligible),
    .last_i  (last_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign xfer      = (state_q == ST_XFER);
  assign handshake = xfer & m_axis_tready;
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    cnt_d   = cnt_q;
    limit_d = limit_q;
    case (state_q)
      ST_IDLE: begin
        if (i_enable) begin
          cnt_d   = '0;
          limit_d = i_pkt_limit;
          state_d = ST_ARB;
        end
      end
      ST_ARB: begin
        if (!i_enable) begin
          state_d = ST_IDLE;
        end else if (arb_valid) begin
          grant_d = arb_idx;
          beat_d  = '0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (handshake) begin
          if (beat_q == BEAT_LAST) begin
            cnt_d  = cnt_inc;
            last_d = grant_q;
            if (limit_q != '0 && cnt_inc == limit_q) state_d = ST_DONE;
            else if (!i_enable)                      state_d = ST_IDLE;
            else                                     state_d = ST_ARB;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (!i_enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= ID_WIDTH'(N_SRC - 1);
      beat_q  <= '0;
      cnt_q   <= '0;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
      limit_q <= limit_d;
    end
  end

  // Grant is frozen for the whole packet, so the FWFT head feeds tdata directly.
  always_comb begin
    m_axis_tdata = '0;
    o_fifo_en    = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (grant_q == ID_WIDTH'(k)) begin
        m_axis_tdata = i_fifo_data[k*DATA_WIDTH +: DATA_WIDTH];
        o_fifo_en[k] = handshake;
      end
    end
  end

  assign m_axis_tvalid = xfer;
  assign m_axis_tlast  = xfer && (beat_q == BEAT_LAST);
  assign m_axis_tdest  = grant_q;
  assign m_axis_tkeep  = '1;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = (state_q == ST_DONE);
  assign o_pkt_cnt     = cnt_q;

endmodule

// File: tb/tb_axis_pkt_sched.sv
// Directed bench for axis_pkt_sched: FIFO model whose head word encodes
// {source, pop sequence}, so order and origin of every beat are checkable.
module tb_axis_pkt_sched;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int PL = 8;
  localparam int LW = 6;
  localparam int IW = 2;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst_L;
  logic              i_enable;
  logic [CW-1:0]     i_pkt_limit;
  logic [NS*DW-1:0]  i_fifo_data;
  logic [NS*LW-1:0]  i_fifo_level;
  logic [NS-1:0]     o_fifo_en;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic [DW-1:0]     m_axis_tdata;
  logic [DW/8-1:0]   m_axis_tkeep;
  logic              m_axis_tlast;
  logic [IW-1:0]     m_axis_tdest;
  logic              o_busy;
  logic              o_done;
  logic [CW-1:0]     o_pkt_cnt;

  int total = 0;
  int bad   = 0;

  int base_lvl [NS] = '{default: 0};
  int pop_cnt  [NS] = '{default: 0};

  logic [DW-1:0] cap_data [PL];
  logic [IW-1:0] cap_dest [PL];
  logic [PL-1:0] cap_last;
  int            cap_bub, cap_unst, cap_poperr, cap_beats;
  bit            cap_to;

  axis_pkt_sched #(
    .N_SRC(NS), .DATA_WIDTH(DW), .PKT_LEN(PL),
    .LVL_WIDTH(LW), .ID_WIDTH(IW), .CNT_WIDTH(CW)
  ) dut (
    .clk           (clk),
    .rst_L         (rst_L),
    .i_enable      (i_enable),
    .i_pkt_limit   (i_pkt_limit),
    .i_fifo_data   (i_fifo_data),
    .i_fifo_level  (i_fifo_level),
    .o_fifo_en     (o_fifo_en),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tdest  (m_axis_tdest),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_pkt_cnt     (o_pkt_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    for (int k = 0; k < NS; k++)
      if (o_fifo_en[k]) pop_cnt[k] <= pop_cnt[k] + 1;

  always_comb begin
    i_fifo_data  = '0;
    i_fifo_level = '0;
    for (int k = 0; k < NS; k++) begin
      i_fifo_data[k*DW +: DW]  = {8'(k), 24'(pop_cnt[k])};
      i_fifo_level[k*LW +: LW] = LW'(base_lvl[k] - pop_cnt[k]);
    end
  end

  task automatic set_level(input int k, input int lvl);
    base_lvl[k] = lvl + pop_cnt[k];
  endtask

  task automatic do_reset();
    rst_L         = 1'b0;
    i_enable      = 1'b0;
    i_pkt_limit   = '0;
    m_axis_tready = 1'b1;
    for (int k = 0; k < NS; k++) set_level(k, 0);
    @(negedge clk);
    @(negedge clk);
    rst_L = 1'b1;
    @(negedge clk);
  endtask

  // Collects one packet, called at a negedge. Stops early when beat == stop_at;
  // drops i_enable when beat == drop_at. Returns at the negedge after the last handshake.
  task automatic recv_pkt(input bit rnd, input int drop_at, input int stop_at);
    int            beat;
    int            cyc;
    bit            hold;
    logic [DW-1:0] pd;
    logic          pl;
    logic [IW-1:0] pdst;
    logic [NS-1:0] exp_en;
    beat = 0; cyc = 0; hold = 0; pd = '0; pl = 1'b0; pdst = '0;
    cap_bub = 0; cap_unst = 0; cap_poperr = 0; cap_to = 0; cap_last = '0;
    while (beat < PL && !cap_to) begin
      if (beat == stop_at) break;
      if (beat == drop_at) i_enable = 1'b0;
      m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (m_axis_tvalid) begin
        if (hold && (m_axis_tdata !== pd || m_axis_tlast !== pl || m_axis_tdest !== pdst))
          cap_unst++;
        exp_en = m_axis_tready ? (NS'(1) << m_axis_tdest) : '0;
        if (o_fifo_en !== exp_en) cap_poperr++;
        if (m_axis_tready) begin
          cap_data[beat] = m_axis_tdata;
          cap_last[beat] = m_axis_tlast;
          cap_dest[beat] = m_axis_tdest;
          beat++;
          hold = 0;
        end else begin
          hold = 1; pd = m_axis_tdata; pl = m_axis_tlast; pdst = m_axis_tdest;
        end
      end else if (beat == 0) begin
        cap_bub++;
      end else begin
        cap_unst++;
      end
      cyc++;
      if (cyc > 200) cap_to = 1;
      @(negedge clk);
    end
    cap_beats     = beat;
    m_axis_tready = 1'b1;
  endtask

  function automatic int data_errs(input int src, input int seq0);
    int n = 0;
    for (int i = 0; i < PL; i++)
      if (cap_data[i] !== {8'(src), 24'(seq0 + i)}) n++;
    return n;
  endfunction

  function automatic int dest_errs(input int src);
    int n = 0;
    for (int i = 0; i < PL; i++)
      if (cap_dest[i] !== IW'(src)) n++;
    return n;
  endfunction

  task automatic test_reset();
    do_reset();
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
    total++; if (m_axis_tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
    total++; if (o_fifo_en !== 4'b0) begin bad++; $display("FAIL reset_fifo_en: got %b want 0000", o_fifo_en); end
    total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    total++; if (o_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", o_done); end
    total++; if (m_axis_tdest !== 2'd0) begin bad++; $display("FAIL reset_tdest: got %0d want 0", m_axis_tdest); end
    total++; if (o_pkt_cnt !== 16'd0) begin bad++; $display("FAIL reset_pkt_cnt: got %0d want 0", o_pkt_cnt); end
    total++; if (m_axis_tkeep !== 4'hf) begin bad++; $display("FAIL reset_tkeep: got %h want f", m_axis_tkeep); end
  endtask

  task automatic test_single();
    int seq0;
    do_reset();
    set_level(2, 8);
    seq0     = pop_cnt[2];
    i_enable = 1'b1;
    @(negedge clk);
    total++; if (o_busy !== 1'b1 || m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL single_arb_cycle: got busy=%b tvalid=%b want 1 0", o_busy, m_axis_tvalid); end
    @(negedge clk);
    total++; if (m_axis_tvalid !== 1'b1 || m_axis_tdest !== 2'd2) begin bad++; $display("FAIL single_first_valid: got tvalid=%b tdest=%0d want 1 2", m_axis_tvalid, m_axis_tdest); end
    recv_pkt(0, -1, -1);
    total++; if (cap_beats !== PL) begin bad++; $display("FAIL single_beats: got %0d want %0d", cap_beats, PL); end
    total++; if (dest_errs(2) !== 0) begin bad++; $display("FAIL single_tdest: got %0d wrong beats want 0", dest_errs(2)); end
    total++; if (cap_last !== 8'h80) begin bad++; $display("FAIL single_tlast: got %h want 80", cap_last); end
    total++; if (data_errs(2, seq0) !== 0) begin bad++; $display("FAIL single_data: got %0d wrong words want 0", data_errs(2, seq0)); end
    total++; if (pop_cnt[2] - seq0 !== PL) begin bad++; $display("FAIL single_pops: got %0d want %0d", pop_cnt[2] - seq0, PL); end
    total++; if (cap_poperr !== 0) begin bad++; $display("FAIL single_pop_strobe: got %0d bad cycles want 0", cap_poperr); end
    total++; if (o_pkt_cnt !== 16'd1) begin bad++; $display("FAIL single_pkt_cnt: got %0d want 1", o_pkt_cnt); end
    total++; if (o_busy !== 1'b1 || m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL single_back_to_arb: got busy=%b tvalid=%b want 1 0", o_busy, m_axis_tvalid); end
    i_enable = 1'b0;
    @(negedge clk);
    total++; if (o_busy !== 1'b0 || o_pkt_cnt !== 16'd1) begin bad++; $display("FAIL single_idle_hold: got busy=%b cnt=%0d want 0 1", o_busy, o_pkt_cnt); end
  endtask

  task automatic test_fairness();
    int src, seq0;
    do_reset();
    for (int k = 0; k < NS; k++) set_level(k, 16);
    i_pkt_limit = 16'd8;
    i_enable    = 1'b1;
    @(negedge clk);
    for (int p = 0; p < 8; p++) begin
      src  = p % NS;
      seq0 = pop_cnt[src];
      recv_pkt(0, -1, -1);
      total++; if (cap_beats !== PL || dest_errs(src) !== 0) begin bad++; $display("FAIL fair_pkt%0d_dest: got beats=%0d tdest0=%0d want %0d %0d", p, cap_beats, cap_dest[0], PL, src); end
      total++; if (cap_bub !== 1) begin bad++; $display("FAIL fair_pkt%0d_bubble: got %0d want 1", p, cap_bub); end
      total++; if (cap_last !== 8'h80 || data_errs(src, seq0) !== 0) begin bad++; $display("FAIL fair_pkt%0d_data: got tlast=%h errs=%0d want 80 0", p, cap_last, data_errs(src, seq0)); end
    end
    total++; if (o_done !== 1'b1 || m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL fair_done: got done=%b tvalid=%b want 1 0", o_done, m_axis_tvalid); end
    total++; if (o_pkt_cnt !== 16'd8) begin bad++; $display("FAIL fair_pkt_cnt: got %0d want 8", o_pkt_cnt); end
    repeat (3) @(negedge clk);
    total++; if (o_done !== 1'b1 || m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL fair_done_hold: got done=%b tvalid=%b want 1 0", o_done, m_axis_tvalid); end
    i_enable = 1'b0;
    @(negedge clk);
    total++; if (o_done !== 1'b0 || o_busy !== 1'b0) begin bad++; $display("FAIL fair_leave_done: got done=%b busy=%b want 0 0", o_done, o_busy); end
  endtask

  task automatic test_backpressure();
    int seq0;
    do_reset();
    set_level(1, 8);
    seq0     = pop_cnt[1];
    i_enable = 1'b1;
    @(negedge clk);
    recv_pkt(1, -1, -1);
    total++; if (cap_to !== 1'b0 || cap_beats !== PL) begin bad++; $display("FAIL bp_beats: got %0d timeout=%b want %0d 0", cap_beats, cap_to, PL); end
    total++; if (cap_unst !== 0) begin bad++; $display("FAIL bp_stable: got %0d unstable cycles want 0", cap_unst); end
    total++; if (cap_poperr !== 0) begin bad++; $display("FAIL bp_pop_strobe: got %0d bad cycles want 0", cap_poperr); end
    total++; if (data_errs(1, seq0) !== 0 || cap_last !== 8'h80) begin bad++; $display("FAIL bp_order: got errs=%0d tlast=%h want 0 80", data_errs(1, seq0), cap_last); end
    total++; if (pop_cnt[1] - seq0 !== PL) begin bad++; $display("FAIL bp_pops: got %0d want %0d", pop_cnt[1] - seq0, PL); end
    i_enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_threshold();
    int  seen;
    bit  found;
    do_reset();
    set_level(1, 7);
    i_enable = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (m_axis_tvalid) seen++;
    end
    total++; if (seen !== 0 || o_busy !== 1'b1) begin bad++; $display("FAIL thr_no_grant: got valid_cycles=%0d busy=%b want 0 1", seen, o_busy); end
    set_level(1, 8);
    found = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (m_axis_tvalid) begin found = 1; break; end
    end
    total++; if (found !== 1'b1 || m_axis_tdest !== 2'd1) begin bad++; $display("FAIL thr_grant: got found=%b tdest=%0d want 1 1", found, m_axis_tdest); end
    recv_pkt(0, -1, -1);
    total++; if (cap_beats !== PL || dest_errs(1) !== 0) begin bad++; $display("FAIL thr_pkt: got beats=%0d want %0d", cap_beats, PL); end
    i_enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_disable_mid();
    do_reset();
    set_level(3, 8);
    i_enable = 1'b1;
    @(negedge clk);
    recv_pkt(0, 3, -1);
    total++; if (cap_beats !== PL || cap_unst !== 0) begin bad++; $display("FAIL dis_complete: got beats=%0d unstable=%0d want %0d 0", cap_beats, cap_unst, PL); end
    total++; if (cap_last !== 8'h80 || dest_errs(3) !== 0) begin bad++; $display("FAIL dis_tlast: got %h want 80", cap_last); end
    total++; if (o_busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL dis_idle: got busy=%b tvalid=%b want 0 0", o_busy, m_axis_tvalid); end
    total++; if (o_pkt_cnt !== 16'd1) begin bad++; $display("FAIL dis_pkt_cnt: got %0d want 1", o_pkt_cnt); end
  endtask

  task automatic test_reset_mid();
    int seq0;
    do_reset();
    set_level(2, 24);
    seq0     = pop_cnt[2];
    i_enable = 1'b1;
    @(negedge clk);
    recv_pkt(0, -1, -1);
    total++; if (o_pkt_cnt !== 16'd1 || dest_errs(2) !== 0) begin bad++; $display("FAIL rst_first_pkt: got cnt=%0d want 1", o_pkt_cnt); end
    recv_pkt(0, -1, 5);
    total++; if (m_axis_tvalid !== 1'b1 || cap_beats !== 5) begin bad++; $display("FAIL rst_mid_pkt: got tvalid=%b beats=%0d want 1 5", m_axis_tvalid, cap_beats); end
    rst_L = 1'b0;
    #1;
    total++; if (m_axis_tvalid !== 1'b0 || o_fifo_en !== 4'b0) begin bad++; $display("FAIL rst_async_out: got tvalid=%b fifo_en=%b want 0 0000", m_axis_tvalid, o_fifo_en); end
    total++; if (o_pkt_cnt !== 16'd0 || o_busy !== 1'b0 || m_axis_tlast !== 1'b0) begin bad++; $display("FAIL rst_async_state: got cnt=%0d busy=%b tlast=%b want 0 0 0", o_pkt_cnt, o_busy, m_axis_tlast); end
    total++; if (pop_cnt[2] - seq0 !== PL + 5) begin bad++; $display("FAIL rst_pops: got %0d want %0d", pop_cnt[2] - seq0, PL + 5); end
    set_level(0, 8);
    set_level(3, 8);
    @(negedge clk);
    rst_L = 1'b1;
    recv_pkt(0, -1, -1);
    total++; if (cap_beats !== PL || cap_dest[0] !== 2'd0) begin bad++; $display("FAIL rst_regrant: got beats=%0d tdest=%0d want %0d 0", cap_beats, cap_dest[0], PL); end
    i_enable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_threshold();
    test_disable_mid();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
